// File: rtl/apb_arb_master.sv
// ---------------------------------------------------------------------------
// apb_arb_master
//   Serialises register-access requests from NUM_REQ local clients onto one
//   APB bus using round-robin arbitration. Each transfer goes through
//   IDLE -> SETUP -> ACCESS. The completion (data, error) is returned to the
//   owning client as a one-cycle req_ack pulse. An ACCESS-phase timeout
//   forces an error completion when the slave never raises pready.
//
// Ports
//   pclk, prst_n          : clock (rising edge), asynchronous active-low reset
//   req_valid/req_write   : per-client request and direction (1 = write)
//   req_addr/wdata/strb   : packed per-client payload, client i at slice i
//   req_ack               : one-hot completion pulse to the owner
//   req_rdata/req_err     : completion data/error, valid only with req_ack
//   busy                  : high while a transfer is in flight
//   gnt_id                : current owner; holds the last owner when idle
//   psel/penable/pwrite   : APB control
//   paddr/pwdata/pstrb    : APB payload, latched at grant
//   prdata/pready/pslverr : APB slave response
// ---------------------------------------------------------------------------
module apb_arb_master #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    parameter int GNT_W      = $clog2(NUM_REQ)
) (
    input  logic                          pclk,
    input  logic                          prst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*4-1:0]          req_strb,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          req_err,
    output logic                          busy,
    output logic [GNT_W-1:0]              gnt_id,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic [DATA_WIDTH-1:0]         pwdata,
    output logic [3:0]                    pstrb,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pready,
    input  logic                          pslverr
);

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [GNT_W-1:0]        r_last_gnt;
    logic [GNT_W-1:0]        r_gnt_id;
    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [3:0]              r_strb;
    logic [CNT_W-1:0]        r_cnt;

    logic                    w_found;
    logic [GNT_W-1:0]        w_pick;
    logic                    w_pick_write;
    logic [ADDR_WIDTH-1:0]   w_pick_addr;
    logic [DATA_WIDTH-1:0]   w_pick_wdata;
    logic [3:0]              w_pick_strb;
    logic                    w_done;

    // Round-robin pick: first requester strictly above last_gnt, otherwise
    // wrap to the lowest requester at or below it. This equals an ascending
    // search from last_gnt+1 modulo NUM_REQ without a modulo operator.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last_gnt;
        for (int unsigned c = 0; c < NUM_REQ; c++) begin
            if (!w_found && req_valid[c] && (GNT_W'(c) > r_last_gnt)) begin
                w_found = 1'b1;
                w_pick  = GNT_W'(c);
            end
        end
        for (int unsigned c = 0; c < NUM_REQ; c++) begin
            if (!w_found && req_valid[c] && (GNT_W'(c) <= r_last_gnt)) begin
                w_found = 1'b1;
                w_pick  = GNT_W'(c);
            end
        end
    end

    // Payload of the picked client.
    always_comb begin
        w_pick_write = 1'b0;
        w_pick_addr  = '0;
        w_pick_wdata = '0;
        w_pick_strb  = '0;
        for (int unsigned c = 0; c < NUM_REQ; c++) begin
            if (w_pick == GNT_W'(c)) begin
                w_pick_write = req_write[c];
                w_pick_addr  = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
                w_pick_wdata = req_wdata[c*DATA_WIDTH +: DATA_WIDTH];
                w_pick_strb  = req_strb[c*4 +: 4];
            end
        end
    end

    // Next-state logic. w_done marks the completing ACCESS cycle; pready
    // takes precedence over the timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                w_done = pready || (r_cnt == CNT_LAST);
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_last_gnt <= GNT_W'(NUM_REQ - 1);
            r_gnt_id   <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_cnt      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_last_gnt <= w_pick;
                        r_gnt_id   <= w_pick;
                        r_write    <= w_pick_write;
                        r_addr     <= w_pick_addr;
                        r_wdata    <= w_pick_wdata;
                        r_strb     <= w_pick_strb;
                    end
                end
                SETUP: begin
                    r_cnt <= '0;
                end
                ACCESS: begin
                    if (!w_done) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        psel      = (r_state == SETUP) || (r_state == ACCESS);
        penable   = (r_state == ACCESS);
        busy      = (r_state != IDLE);
        gnt_id    = r_gnt_id;
        pwrite    = r_write;
        paddr     = r_addr;
        pwdata    = r_wdata;
        pstrb     = r_strb;
        req_ack   = '0;
        req_rdata = '0;
        req_err   = 1'b0;
        if (w_done) begin
            req_ack = NUM_REQ'(1) << r_gnt_id;
            if (pready) begin
                req_rdata = prdata;
                req_err   = pslverr;
            end else begin
                req_err   = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_arb_master
//   Randomised clients and slave around apb_arb_master (3 clients, timeout 4).
//   A transaction-level reference model predicts grants, bus payload and
//   completions; expectations go into queues that an independent monitor
//   drains on the falling clock edge. Two resets are injected mid-ACCESS.
// ---------------------------------------------------------------------------
module tb_apb_arb_master;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int GW = $clog2(N);

    logic              pclk   = 1'b0;
    logic              prst_n = 1'b1;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*4-1:0]    req_strb;
    logic [N-1:0]      req_ack;
    logic [DW-1:0]     req_rdata;
    logic              req_err;
    logic              busy;
    logic [GW-1:0]     gnt_id;
    logic              psel, penable, pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [3:0]        pstrb;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;

    always #5 pclk = ~pclk;

    apb_arb_master #(
        .NUM_REQ   (N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .pclk     (pclk),
        .prst_n   (prst_n),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_strb (req_strb),
        .req_ack  (req_ack),
        .req_rdata(req_rdata),
        .req_err  (req_err),
        .busy     (busy),
        .gnt_id   (gnt_id),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    typedef struct {
        logic          psel;
        logic          penable;
        logic          busy;
        int            gnt;
        logic          pwrite;
        logic [AW-1:0] paddr;
        logic [DW-1:0] pwdata;
        logic [3:0]    pstrb;
        logic          ack_exp;
    } ctl_t;

    typedef struct {
        logic [N-1:0]  ack;
        logic [DW-1:0] rdata;
        logic          err;
    } ack_t;

    ctl_t ctl_q[$];
    ack_t ack_q[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    bit            m_active;
    int            m_owner;
    int            m_k;          // 0 = SETUP cycle, k>=1 = k-th ACCESS cycle
    int            m_last;
    int            m_gnt;
    int            m_wait;       // wait states planned; >= TO means timeout
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_strb;
    bit            prev_done;

    bit            pending[N];
    bit            acked_prev[N];
    logic          c_write[N];
    logic [AW-1:0] c_addr[N];
    logic [DW-1:0] c_wdata[N];
    logic [3:0]    c_strb[N];

    task automatic rand_payload(input int i);
        c_write[i] = 1'($urandom_range(0, 1));
        c_addr[i]  = AW'($urandom);
        c_wdata[i] = $urandom;
        c_strb[i]  = 4'($urandom);
    endtask

    task automatic apply_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = pending[i];
            req_write[i]            = c_write[i];
            req_addr[i*AW +: AW]    = c_addr[i];
            req_wdata[i*DW +: DW]   = c_wdata[i];
            req_strb[i*4 +: 4]      = c_strb[i];
        end
    endtask

    task automatic model_reset();
        m_active  = 0;
        m_owner   = 0;
        m_k       = 0;
        m_last    = N - 1;
        m_gnt     = 0;
        prev_done = 0;
        for (int i = 0; i < N; i++) acked_prev[i] = 0;
    endtask

    // Advance the model across the rising edge that just happened.
    task automatic model_edge();
        if (m_active) begin
            if (m_k == 0) m_k = 1;
            else if (prev_done) m_active = 0;
            else m_k++;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (pending[c]) begin
                    m_active = 1;
                    m_owner  = c;
                    m_last   = c;
                    m_gnt    = c;
                    m_k      = 0;
                    m_write  = c_write[c];
                    m_addr   = c_addr[c];
                    m_wdata  = c_wdata[c];
                    m_strb   = c_strb[c];
                    m_wait   = $urandom_range(0, 5);
                    break;
                end
            end
        end
    endtask

    task automatic push_idle_zero();
        ctl_t c;
        c.psel = 0; c.penable = 0; c.busy = 0; c.gnt = 0;
        c.pwrite = 0; c.paddr = '0; c.pwdata = '0; c.pstrb = '0; c.ack_exp = 0;
        ctl_q.push_back(c);
    endtask

    // Client and slave stimulus for the current cycle plus its expectations.
    task automatic drive_cycle();
        ctl_t c;
        ack_t a;
        bit   done;
        for (int i = 0; i < N; i++) begin
            if (acked_prev[i]) begin
                if ($urandom_range(0, 1) == 1) begin
                    rand_payload(i);
                    pending[i] = 1;
                end else begin
                    pending[i] = 0;
                end
            end else if (m_active && m_owner == i) begin
                if (pending[i] && $urandom_range(0, 9) == 0) pending[i] = 0;
                if ($urandom_range(0, 2) == 0) rand_payload(i);
            end else if (!pending[i] && $urandom_range(0, 3) == 0) begin
                rand_payload(i);
                pending[i] = 1;
            end
        end
        apply_reqs();

        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
        done    = 0;
        if (m_active && m_k >= 1) begin
            pready = (m_k == m_wait + 1);
            done   = pready || (m_k == TO);
        end else begin
            pready = 1'($urandom_range(0, 1));
        end

        c.psel    = m_active;
        c.penable = m_active && (m_k >= 1);
        c.busy    = m_active;
        c.gnt     = m_gnt;
        c.pwrite  = m_write;
        c.paddr   = m_addr;
        c.pwdata  = m_wdata;
        c.pstrb   = m_strb;
        c.ack_exp = done;
        ctl_q.push_back(c);

        if (done) begin
            a.ack   = N'(1) << m_owner;
            a.rdata = pready ? prdata : '0;
            a.err   = pready ? pslverr : 1'b1;
            ack_q.push_back(a);
        end
        for (int i = 0; i < N; i++) acked_prev[i] = done && (m_owner == i);
        prev_done = done;
    endtask

    task automatic check_reset_zero();
        chk("rst_ctl", 64'({psel, penable, pwrite, busy, req_err, gnt_id, req_ack, pstrb}), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_rdata", 64'(req_rdata), 64'd0);
    endtask

    task automatic do_reset();
        prst_n = 1'b0;
        pready = 1'b0;
        #1;
        check_reset_zero();
        pending[0] = 1;
        apply_reqs();
        push_idle_zero();
        repeat (2) begin
            @(posedge pclk);
            #1;
            push_idle_zero();
        end
        @(posedge pclk);
        #1;
        prst_n = 1'b1;
        model_reset();
        drive_cycle();
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge pclk);
            if (ctl_q.size() != 0) begin
                ctl_t c;
                c = ctl_q.pop_front();
                chk("psel", 64'(psel), 64'(c.psel));
                chk("penable", 64'(penable), 64'(c.penable));
                chk("busy", 64'(busy), 64'(c.busy));
                chk("gnt_id", 64'(gnt_id), 64'(c.gnt));
                if (c.psel) begin
                    chk("paddr", 64'(paddr), 64'(c.paddr));
                    chk("pwrite", 64'(pwrite), 64'(c.pwrite));
                    chk("pwdata", 64'(pwdata), 64'(c.pwdata));
                    chk("pstrb", 64'(pstrb), 64'(c.pstrb));
                end
                if (c.ack_exp || req_ack != '0) begin
                    if (ack_q.size() == 0 || !c.ack_exp) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL ack_pulse: got req_ack 0x%0h expected none at %0t", req_ack, $time);
                    end else begin
                        ack_t a;
                        a = ack_q.pop_front();
                        chk("req_ack", 64'(req_ack), 64'(a.ack));
                        chk("req_rdata", 64'(req_rdata), 64'(a.rdata));
                        chk("req_err", 64'(req_err), 64'(a.err));
                    end
                end else begin
                    chk("idle_rdata_err", 64'({req_rdata, req_err}), 64'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit want_rst;
        want_rst  = 0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        for (int i = 0; i < N; i++) begin
            pending[i] = 0;
            c_write[i] = 0;
            c_addr[i]  = '0;
            c_wdata[i] = '0;
            c_strb[i]  = '0;
        end
        model_reset();
        m_write = 0; m_addr = '0; m_wdata = '0; m_strb = '0; m_wait = 0;

        #2 prst_n = 1'b0;
        #1 check_reset_zero();
        repeat (2) @(posedge pclk);
        #1;
        prst_n = 1'b1;
        drive_cycle();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge pclk);
            #1;
            model_edge();
            if (cyc == 800 || cyc == 1900) want_rst = 1;
            if (want_rst && m_active && m_k >= 1) begin
                want_rst = 0;
                do_reset();
            end else begin
                drive_cycle();
            end
        end

        @(negedge pclk);
        #1;
        chk("queues_drained", {32'(ctl_q.size()), 32'(ack_q.size())}, 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_arb_master.md
# apb_arb_master

Multi-requester APB master with round-robin arbitration. It takes register-access requests from up to NUM_REQ local clients and serialises them onto a single APB bus, where the bus is driven to an apb_slave instance. Each transfer is sequenced through the IDLE, SETUP and ACCESS phases. Completion (data, error) is returned to the owning client, and a timeout guards against a slave that never raises pready.

## Interface
- NUM_REQ, 2: number of requesters, 2..8
- ADDR_WIDTH, 12: APB address width
- DATA_WIDTH, 32: APB data width
- TIMEOUT, 16: maximum ACCESS cycles before forced error completion, ≥2
- GNT_W, $clog2(NUM_REQ): width of gnt_id (derived; do not override)
- pclk  in  1  clock; all logic on rising edge
- prst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-client request; held high until req_ack
- req_write  in  NUM_REQ  per-client 1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_strb  in  NUM_REQ*4  packed byte strobes
- req_ack  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner
- req_rdata  out  DATA_WIDTH  read data, valid only while req_ack != 0
- req_err  out  1  error flag, valid only while req_ack != 0
- busy  out  1  high while state != IDLE
- gnt_id  out  GNT_W  index of the current owner; holds last owner when idle
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  ADDR_WIDTH; pwdata  out  DATA_WIDTH; pstrb  out  4  APB payload
- prdata  in  DATA_WIDTH; pready  in  1; pslverr  in  1  APB response

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state is IDLE.
- **IDLE**
  - If any req_valid is high, grant the first requesting client searching from last_gnt+1 (mod NUM_REQ), ascending.
  - Latch that client's write, addr, wdata and strb into registers. Update last_gnt and gnt_id. Go to SETUP.
- **SETUP**
  - psel=1, penable=0.
  - Always go to ACCESS next cycle. Clear the timeout counter.
- **ACCESS**
  - psel=1, penable=1.
  - If pready=1: req_ack[gnt_id]=1, req_rdata=prdata, req_err=pslverr. Go to IDLE.
  - Else if the counter equals TIMEOUT-1: req_ack[gnt_id]=1, req_rdata=0, req_err=1. Go to IDLE.
  - Otherwise increment the counter.
- paddr, pwrite, pwdata and pstrb come from the latched registers. They are stable for the whole SETUP+ACCESS period, independent of later req_* changes.
- req_ack, req_rdata and req_err are combinational from state, pready, pslverr, prdata and the counter. Outside an ack, req_rdata=0 and req_err=0.
- If a client drops req_valid after being granted, the transfer still completes and the ack is still pulsed. The client ignores it.
- Other clients' req_valid changes during a transfer have no effect until IDLE.
- The round-robin pointer last_gnt resets to NUM_REQ-1, so client 0 wins the first arbitration.
- **Reset assertion (any state, including mid-transfer):** immediately
  - FSM to IDLE;
  - psel=penable=pwrite=0, paddr=pwdata=pstrb=0;
  - req_ack=0, req_rdata=0, req_err=0;
  - busy=0, gnt_id=0, counter=0, last_gnt=NUM_REQ-1.
  
  The interrupted transfer is dropped with no ack.

## Timing
- Request sampled high in IDLE at edge N: SETUP during cycle N+1, ACCESS from N+2.
- With zero wait states, req_ack pulses in cycle N+2. The FSM is back in IDLE at N+3.
- Minimum spacing between transfers is 3 cycles (IDLE, SETUP, ACCESS). There is no back-to-back SETUP.
- Client protocol: deassert req_valid, or present a new request, in the cycle after req_ack. Since the FSM is in IDLE then, a request still high is treated as new.
- Each wait state (pready=0 in ACCESS) adds one cycle.
- Timeout: after TIMEOUT consecutive ACCESS cycles with pready=0, the ack with err=1 fires in the TIMEOUT-th ACCESS cycle. psel drops the next cycle.
- If pready=1 in the same cycle the count reaches TIMEOUT-1, pready wins: normal completion with prdata and pslverr.
- Simultaneous requests are resolved purely by the round-robin pointer. No client waits more than NUM_REQ-1 transfers.

## Test plan
- **Single read, zero wait.** NUM_REQ=2. Client 0 reads 0x010, slave returns prdata=0xDEADBEEF with pready=1 in its first ACCESS cycle. Required:
  - psel high 2 cycles, penable high 1 cycle;
  - req_ack=2'b01 in that cycle with req_rdata=0xDEADBEEF and req_err=0;
  - busy low one cycle later.
- **Simultaneous requests.** Clients 0 and 1 hold req_valid continuously, each re-requesting after its ack. Required grant order from reset is 0,1,0,1, with gnt_id following and each transfer's paddr matching its client's addr.
- **Write with wait states.** Client 1 writes 0x12345678, strb=4'b0011, to 0x0A4. The slave holds pready=0 for 3 ACCESS cycles. Required:
  - ack on the 4th ACCESS cycle;
  - pwdata, pstrb and paddr stable for all 5 psel cycles.
- **Slave error.** pslverr=1 with pready=1 on a read. Required: req_ack pulses with req_err=1 and req_rdata=prdata.
- **Timeout.** TIMEOUT=4, pready held at 0. Required:
  - ack with req_err=1 and req_rdata=0 in the 4th ACCESS cycle;
  - psel=0 the next cycle;
  - the next pending client is granted afterwards.
- **Reset mid-transfer.** Assert prst_n=0 during ACCESS. Required:
  - all outputs go to 0 asynchronously and no req_ack occurs;
  - after release, client 0 is granted first.
